// File: rtl/ddram_pkg.sv
// Shared widths, FSM state type and burst-length helper for the DDRAM responder.
package ddram_pkg;

  localparam int unsigned DDR_ADDR_W  = 29;
  localparam int unsigned DDR_DATA_W  = 64;
  localparam int unsigned DDR_BURST_W = 8;
  localparam int unsigned DDR_BE_W    = DDR_DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRdWait,
    StRdData
  } ddr_resp_state_t;

  // A burst count of zero is served as a single beat.
  function automatic logic [DDR_BURST_W-1:0] burst_len(input logic [DDR_BURST_W-1:0] cnt);
    return (cnt == '0) ? DDR_BURST_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/ddram_bram_store.sv
// Single-port block RAM backing store: per-byte write enables, synchronous read.
module ddram_bram_store import ddram_pkg::*; #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  we,
  input  logic [DDR_BE_W-1:0]   be,
  input  logic [DDR_DATA_W-1:0] wdata,
  output logic [DDR_DATA_W-1:0] rdata
);

  logic [DDR_DATA_W-1:0] mem [2**ADDR_W];

  // Byte-masked write and registered read; the responder never reads and writes in one cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DDR_BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ddram_bram_responder.sv
// Memory-side responder for the MiSTer DDRAM burst interface, served from block RAM.
// Adds programmable read latency and periodic write back-pressure.
module ddram_bram_responder import ddram_pkg::*; #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned WR_STALL = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DDR_ADDR_W-1:0]  DDRAM_ADDR,
  input  logic [DDR_BURST_W-1:0] DDRAM_BURSTCNT,
  input  logic                   DDRAM_RD,
  input  logic                   DDRAM_WE,
  input  logic [DDR_DATA_W-1:0]  DDRAM_DIN,
  input  logic [DDR_BE_W-1:0]    DDRAM_BE,
  output logic                   DDRAM_BUSY,
  output logic [DDR_DATA_W-1:0]  DDRAM_DOUT,
  output logic                   DDRAM_DOUT_READY,
  output logic                   proto_err
);

  localparam int unsigned STALL_W = 16;

  ddr_resp_state_t        state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [DDR_BURST_W-1:0] rem_q, rem_d;
  logic [3:0]             lat_q, lat_d;
  logic [STALL_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                   stall_q, stall_d;
  logic                   err_q, err_d;
  logic [DDR_DATA_W-1:0]  dout_hold_q;

  logic                   busy, dout_ready, wr_accept, ram_we;
  logic [ADDR_W-1:0]      ram_addr, cmd_addr;
  logic [DDR_DATA_W-1:0]  ram_rdata;
  logic [DDR_BURST_W-1:0] cmd_len;
  logic                   unused_addr_hi;

  // Upper address bits are ignored so the store aliases (wraps) across the DDR space.
  assign cmd_addr       = DDRAM_ADDR[ADDR_W-1:0];
  assign unused_addr_hi = ^DDRAM_ADDR[DDR_ADDR_W-1:ADDR_W];
  assign cmd_len        = burst_len(DDRAM_BURSTCNT);
  assign busy           = (state_q == StRdWait) || (state_q == StRdData) || stall_q;

  // Next-state, burst pointer and RAM port control.
  // ram_addr runs one beat ahead of the data so the synchronous read lines up with DOUT_READY.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    lat_d      = lat_q;
    err_d      = 1'b0;
    ram_addr   = ptr_q;
    ram_we     = 1'b0;
    wr_accept  = 1'b0;
    dout_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        ram_addr = cmd_addr;
        if (!busy) begin
          if (DDRAM_WE) begin
            // Write wins a simultaneous read; the read is dropped and flagged.
            ram_we    = 1'b1;
            wr_accept = 1'b1;
            err_d     = DDRAM_RD;
            ptr_d     = cmd_addr + 1'b1;
            rem_d     = cmd_len - 8'd1;
            if (cmd_len != 8'd1) state_d = StWrite;
          end else if (DDRAM_RD) begin
            rem_d = cmd_len;
            if (RD_LAT == 0) begin
              ptr_d   = cmd_addr + 1'b1;
              state_d = StRdData;
            end else begin
              ptr_d   = cmd_addr;
              lat_d   = 4'(RD_LAT);
              state_d = StRdWait;
            end
          end
        end
      end
      StWrite: begin
        err_d = DDRAM_RD;
        if (DDRAM_WE && !busy) begin
          ram_we    = 1'b1;
          wr_accept = 1'b1;
          ptr_d     = ptr_q + 1'b1;
          rem_d     = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = StIdle;
        end
      end
      StRdWait: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = StRdData;
        end
      end
      StRdData: begin
        dout_ready = 1'b1;
        ptr_d      = ptr_q + 1'b1;
        rem_d      = rem_q - 8'd1;
        if (rem_q == 8'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Every WR_STALL-th accepted write beat raises BUSY for the following cycle.
  always_comb begin
    stall_d     = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if ((WR_STALL != 0) && wr_accept) begin
      if (stall_cnt_q == STALL_W'(WR_STALL - 1)) begin
        stall_cnt_d = '0;
        stall_d     = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // State, counters, registered error pulse and DOUT hold register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      rem_q       <= '0;
      lat_q       <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
      dout_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      lat_q       <= lat_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      if (dout_ready) dout_hold_q <= ram_rdata;
    end
  end

  ddram_bram_store #(
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (DDRAM_BE),
    .wdata (DDRAM_DIN),
    .rdata (ram_rdata)
  );

  assign DDRAM_BUSY       = busy;
  assign DDRAM_DOUT_READY = dout_ready;
  assign DDRAM_DOUT       = dout_ready ? ram_rdata : dout_hold_q;
  assign proto_err        = err_q;

endmodule

// File: tb/tb_ddram_bram_responder.sv
// Self-checking bench: a cycle-timeline model of the responder checked every cycle, plus
// directed scenarios with literal expectations and a randomized command phase.
module tb_ddram_bram_responder;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned WR_STALL = 2;
  localparam int unsigned DEPTH    = 2**ADDR_W;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [28:0] addr = '0;
  logic [7:0]  burstcnt = '0;
  logic        rd = 1'b0, we = 1'b0;
  logic [63:0] din = '0;
  logic [7:0]  be = '0;
  logic        busy_o, ready_o, err_o;
  logic [63:0] dout_o;

  always #5 clk = ~clk;

  ddram_bram_responder #(
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .WR_STALL (WR_STALL)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .DDRAM_ADDR       (addr),
    .DDRAM_BURSTCNT   (burstcnt),
    .DDRAM_RD         (rd),
    .DDRAM_WE         (we),
    .DDRAM_DIN        (din),
    .DDRAM_BE         (be),
    .DDRAM_BUSY       (busy_o),
    .DDRAM_DOUT       (dout_o),
    .DDRAM_DOUT_READY (ready_o),
    .proto_err        (err_o)
  );

  typedef struct {
    int          c;
    logic [63:0] d;
  } beat_t;

  int vec = 0, miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: memory image plus a timeline of busy windows, returned beats and error pulses.
  logic [63:0] mem_m [DEPTH];
  beat_t       exp_q[$];
  beat_t       got_q[$];
  bit          err_at[int];
  int          rd_start = 1, rd_end = 0, stall_at = -1;
  bit          wr_active = 0;
  int          wr_rem = 0, beats = 0;
  logic [11:0] wr_ptr = '0;
  logic [63:0] last_dout = '0;
  int          dut_err_cnt = 0;
  logic [63:0] wlog [256];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    err_at.delete();
    rd_start  = 1;
    rd_end    = 0;
    stall_at  = -1;
    wr_active = 0;
    wr_rem    = 0;
    beats     = 0;
    last_dout = '0;
  endtask

  task automatic merge(input logic [11:0] a);
    for (int i = 0; i < 8; i++) if (be[i]) mem_m[a][8*i +: 8] = din[8*i +: 8];
  endtask

  // Apply the inputs of the current cycle to the model, given the BUSY it expects now.
  task automatic model_step(input bit busy_now);
    int          n;
    bit          beat;
    bit          in_rd;
    logic [11:0] a;
    beat  = 0;
    in_rd = (cyc >= rd_start) && (cyc <= rd_end);
    n     = (burstcnt == 0) ? 1 : int'(burstcnt);
    a     = addr[11:0];
    if (in_rd) return;
    if (wr_active) begin
      if (rd) err_at[cyc+1] = 1;
      if (we && !busy_now) begin
        merge(wr_ptr);
        wr_ptr = wr_ptr + 12'd1;
        wr_rem--;
        beat = 1;
        if (wr_rem == 0) wr_active = 0;
      end
    end else if (!busy_now) begin
      if (we) begin
        merge(a);
        wr_ptr    = a + 12'd1;
        wr_rem    = n - 1;
        wr_active = (wr_rem != 0);
        beat      = 1;
        if (rd) err_at[cyc+1] = 1;
      end else if (rd) begin
        for (int k = 0; k < n; k++) exp_q.push_back('{cyc + 1 + RD_LAT + k, mem_m[12'(a + k)]});
        rd_start = cyc + 1;
        rd_end   = cyc + RD_LAT + n;
      end
    end
    if (beat) begin
      beats++;
      if (beats % WR_STALL == 0) stall_at = cyc + 1;
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  bit          e_busy, e_rdy, e_err;
  logic [63:0] e_dout;
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("busy_rst", 64'(busy_o), 64'd0);
      chk("ready_rst", 64'(ready_o), 64'd0);
      chk("dout_rst", dout_o, 64'd0);
      chk("err_rst", 64'(err_o), 64'd0);
      model_clear();
    end else begin
      e_busy = ((cyc >= rd_start) && (cyc <= rd_end)) || (cyc == stall_at);
      e_rdy  = (exp_q.size() > 0) && (exp_q[0].c == cyc);
      e_dout = last_dout;
      if (e_rdy) begin
        e_dout = exp_q[0].d;
        void'(exp_q.pop_front());
      end
      e_err = err_at.exists(cyc);
      chk("busy", 64'(busy_o), 64'(e_busy));
      chk("ready", 64'(ready_o), 64'(e_rdy));
      chk("dout", dout_o, e_dout);
      chk("proto_err", 64'(err_o), 64'(e_err));
      last_dout = e_dout;
      if (ready_o) got_q.push_back('{cyc, dout_o});
      if (err_o) dut_err_cnt++;
      model_step(e_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current command/beat until BUSY is low at the sampling point.
  task automatic wait_accept(input string nm, output int acc_cyc);
    int t;
    t       = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (!busy_o) begin
        acc_cyc = cyc;
        break;
      end
      t++;
      if (t > 64) begin
        vec++;
        miss++;
        $display("FAIL %s_timeout cyc=%0d got=busy expected=accept", nm, cyc);
        break;
      end
    end
    tick();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (cyc <= rd_end) begin
      tick();
      t++;
      if (t > 400) begin
        vec++;
        miss++;
        $display("FAIL idle_timeout cyc=%0d got=busy expected=idle", cyc);
        break;
      end
    end
  endtask

  task automatic wr_burst(input logic [28:0] a, input logic [7:0] bc, input logic [7:0] bmask,
                          input bit use_fix, input logic [63:0] fix_d, input int bub_after,
                          input int bub_len, input bit rd_bub, input bit rd_first);
    int n, acc;
    n = (bc == 0) ? 1 : int'(bc);
    for (int b = 0; b < n; b++) begin
      wlog[b] = use_fix ? fix_d : {$urandom, $urandom};
      we = 1'b1;
      din = wlog[b];
      be = bmask;
      if (b == 0) begin
        addr     = a;
        burstcnt = bc;
        rd       = rd_first;
      end else begin
        addr     = 29'($urandom);
        burstcnt = 8'($urandom);
      end
      wait_accept("wr", acc);
      rd = 1'b0;
      if (b == bub_after && b != n - 1) begin
        we = 1'b0;
        for (int k = 0; k < bub_len; k++) begin
          rd = rd_bub && (k == 0);
          tick();
        end
        rd = 1'b0;
      end
    end
    we = 1'b0;
  endtask

  task automatic rd_cmd(input logic [28:0] a, input logic [7:0] bc, input bit junk,
                        output int t_acc);
    got_q.delete();
    rd       = 1'b1;
    addr     = a;
    burstcnt = bc;
    wait_accept("rd", t_acc);
    rd = 1'b0;
    if (junk) begin
      for (int k = 0; k < RD_LAT; k++) begin
        rd   = 1'($urandom);
        we   = 1'($urandom);
        din  = {$urandom, $urandom};
        addr = 29'($urandom);
        tick();
      end
      rd = 1'b0;
      we = 1'b0;
    end
    wait_idle();
  endtask

  int t_acc, n0, tw;
  logic [28:0] ra;

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Fill the two regions the bench uses so every read has a known model value.
    wr_burst(29'h000, 8'd64, 8'hFF, 0, '0, -1, 0, 0, 0);
    wr_burst(29'hFC0, 8'd64, 8'hFF, 0, '0, -1, 0, 0, 0);

    // Single beat write then read: first beat three cycles after accept.
    wr_burst(29'h010, 8'd1, 8'hFF, 1, 64'h1122334455667788, -1, 0, 0, 0);
    rd_cmd(29'h010, 8'd1, 0, t_acc);
    chk("t1_nbeats", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) begin
      chk("t1_latency", 64'(got_q[0].c - t_acc), 64'd3);
      chk("t1_data", got_q[0].d, 64'h1122334455667788);
    end

    // Four-beat write with a two-cycle bubble, four-beat read back-to-back.
    wr_burst(29'h020, 8'd4, 8'hFF, 0, '0, 1, 2, 0, 0);
    rd_cmd(29'h020, 8'd4, 0, t_acc);
    chk("t2_nbeats", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("t2_span", 64'(got_q[3].c - got_q[0].c), 64'd3);
      for (int i = 0; i < 4; i++) chk("t2_data", got_q[i].d, wlog[i]);
    end

    // Byte enables: low four bytes cleared over an all-ones word.
    wr_burst(29'h018, 8'd1, 8'hFF, 1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 0, 0);
    wr_burst(29'h018, 8'd0, 8'h0F, 1, 64'h0, -1, 0, 0, 0);
    rd_cmd(29'h018, 8'd1, 0, t_acc);
    chk("t3_nbeats", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) chk("t3_data", got_q[0].d, 64'hFFFF_FFFF_0000_0000);

    // Burst wrapping at the top of the store; upper address bits are aliased away.
    wr_burst(29'h1000_0FFF, 8'd3, 8'hFF, 0, '0, -1, 0, 0, 0);
    chk("t4_model_wrap", mem_m[12'h000], wlog[1]);
    rd_cmd(29'h0FFF, 8'd3, 0, t_acc);
    chk("t4_nbeats", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) for (int i = 0; i < 3; i++) chk("t4_data", got_q[i].d, wlog[i]);

    // Protocol errors: RD with the first write beat, and RD during a write bubble.
    dut_err_cnt = 0;
    got_q.delete();
    wr_burst(29'h030, 8'd3, 8'hFF, 0, '0, 0, 1, 1, 1);
    tick();
    tick();
    chk("t5_err_pulses", 64'(dut_err_cnt), 64'd2);
    chk("t5_no_rdata", 64'(got_q.size()), 64'd0);
    rd_cmd(29'h030, 8'd3, 0, t_acc);
    if (got_q.size() == 3) for (int i = 0; i < 3; i++) chk("t5_data", got_q[i].d, wlog[i]);

    // Reset during the second beat of an eight-beat read.
    got_q.delete();
    rd       = 1'b1;
    addr     = 29'h020;
    burstcnt = 8'd8;
    wait_accept("t6_rd", t_acc);
    rd = 1'b0;
    n0 = got_q.size();
    tw = 0;
    while (got_q.size() == n0 && tw < 40) begin
      tick();
      tw++;
    end
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    rd_cmd(29'h010, 8'd1, 0, t_acc);
    chk("t6_nbeats", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) chk("t6_data", got_q[0].d, 64'h1122334455667788);

    // Stalled write burst: no beat may be written twice.
    wr_burst(29'h008, 8'd5, 8'hFF, 0, '0, -1, 0, 0, 0);
    rd_cmd(29'h008, 8'd5, 0, t_acc);
    chk("t6_stall_nbeats", 64'(got_q.size()), 64'd5);
    if (got_q.size() == 5) for (int i = 0; i < 5; i++) chk("t6_stall_data", got_q[i].d, wlog[i]);

    // Randomized commands against the model.
    for (int op = 0; op < 60; op++) begin
      ra = ($urandom_range(0, 1) == 0) ? 29'($urandom_range(0, 'h38))
                                       : 29'('hFC0 + $urandom_range(0, 'h3F));
      ra = ra | (29'($urandom_range(0, 'h1FFFF)) << 12);
      if ($urandom_range(0, 1) == 0) begin
        wr_burst(ra, 8'($urandom_range(0, 6)),
                 ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom), 0, '0,
                 int'($urandom_range(0, 4)) - 1, int'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      end else begin
        rd_cmd(ra, 8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), t_acc);
      end
      if ($urandom_range(0, 2) == 0) tick();
    end

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
